// File: rtl/xm_bus_pkg.sv
// xm_bus_pkg: shared arbiter state encoding, bus widths and Wishbone byte-select codes.
package xm_bus_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam int XM_WORD = 16;
  localparam int XM_ADR_W = 15;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO = 2'b01;
  localparam logic [1:0] SEL_HI = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;
endpackage

// File: rtl/xm_bus_timeout.sv
// xm_bus_timeout: counts strobed cycles without ack and flags expiry at TIMEOUT-1.
// Only built when XM_BUS_ARB_TIMEOUT_EN is defined.
`ifdef XM_BUS_ARB_TIMEOUT_EN
module xm_bus_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clr,
  input  logic run,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expire = run & (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d = clr ? '0 : run ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule
`endif

// File: rtl/xm_bus_arbiter.sv
// xm_bus_arbiter: two-master round-robin Wishbone-classic arbiter with cycle-locked grants.
// Define XM_BUS_ARB_TIMEOUT_EN to add a no-ack watchdog that errors and releases the bus.
module xm_bus_arbiter
  import xm_bus_pkg::*;
#(
  parameter int WORD = XM_WORD,
  parameter int ADR_W = WORD - (WORD / 8) + 1,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [1:0]       m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [WORD-1:0]  m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [WORD-1:0]  m0_dat_o,
  output logic             m0_gnt_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [1:0]       m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [WORD-1:0]  m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [WORD-1:0]  m1_dat_o,
  output logic             m1_gnt_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [1:0]       sel_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [WORD-1:0]  dat_o,
  input  logic             ack_i,
  input  logic [WORD-1:0]  dat_i
);
  arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic own0, own1, req0, req1, rel, expire;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
`ifdef XM_BUS_ARB_TIMEOUT_EN
  // A master that timed out stays locked out until it drops cyc for a cycle.
  logic [1:0] blk_q, blk_d;
  xm_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i,
    .arst_i,
    .clr(ack_i | ~cyc_o),
    .run(stb_o & ~ack_i),
    .expire
  );
  assign blk_d = (blk_q | {own1 & expire, own0 & expire}) & {m1_cyc_i, m0_cyc_i};
  assign req0 = m0_cyc_i & ~blk_q[0];
  assign req1 = m1_cyc_i & ~blk_q[1];
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) blk_q <= '0;
    else blk_q <= blk_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign expire = 1'b0;
  assign req0 = m0_cyc_i;
  assign req1 = m1_cyc_i;
`endif
  assign rel = own0 ? ~m0_cyc_i | expire : own1 ? ~m1_cyc_i | expire : 1'b0;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE)
      state_d = (req0 & (~req1 | last_q)) ? OWN0 : req1 ? OWN1 : IDLE;
    else if (rel) begin
      last_d = own1;
      state_d = expire ? IDLE : (own0 & req1) ? OWN1 : (own1 & req0) ? OWN0 : IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state_q <= IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  assign cyc_o = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign stb_o = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign we_o = (own0 & m0_we_i) | (own1 & m1_we_i);
  assign sel_o = own0 ? m0_sel_i : own1 ? m1_sel_i : SEL_NONE;
  assign adr_o = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
  assign dat_o = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
  assign m0_ack_o = own0 & ack_i & stb_o;
  assign m1_ack_o = own1 & ack_i & stb_o;
  assign m0_err_o = own0 & expire;
  assign m1_err_o = own1 & expire;
  assign m0_dat_o = own0 ? dat_i : '0;
  assign m1_dat_o = own1 ? dat_i : '0;
  assign m0_gnt_o = own0;
  assign m1_gnt_o = own1;
endmodule

// File: tb/tb_xm_bus_arbiter.sv
// tb_xm_bus_arbiter: directed and random checks of xm_bus_arbiter against an ownership model.
module tb_xm_bus_arbiter;
  localparam int W = 16;
  localparam int AW = 15;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic c[2], s[2], w[2];
  logic [1:0] sl[2];
  logic [AW-1:0] a[2];
  logic [W-1:0] d[2];
  logic ack_i;
  logic [W-1:0] dat_i;
  logic ack_o[2], err_o[2], gnt_o[2];
  logic [W-1:0] dat_m[2];
  logic cyc_o, stb_o, we_o;
  logic [1:0] sel_o;
  logic [AW-1:0] adr_o;
  logic [W-1:0] dat_o;

  int compared, mismatched;
  int own, last, tcnt;
  bit blk[2];

  always #5 clk = ~clk;

  xm_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .arst_i(arst),
    .m0_cyc_i(c[0]), .m0_stb_i(s[0]), .m0_we_i(w[0]), .m0_sel_i(sl[0]),
    .m0_adr_i(a[0]), .m0_dat_i(d[0]), .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]),
    .m0_dat_o(dat_m[0]), .m0_gnt_o(gnt_o[0]),
    .m1_cyc_i(c[1]), .m1_stb_i(s[1]), .m1_we_i(w[1]), .m1_sel_i(sl[1]),
    .m1_adr_i(a[1]), .m1_dat_i(d[1]), .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]),
    .m1_dat_o(dat_m[1]), .m1_gnt_o(gnt_o[1]),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Owner is stalled on the last allowed no-ack strobe cycle.
  function automatic bit expiring();
`ifdef XM_BUS_ARB_TIMEOUT_EN
    return own >= 0 && s[own] && !ack_i && tcnt == TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    own = -1;
    last = 1;
    tcnt = 0;
    blk[0] = 0;
    blk[1] = 0;
  endtask

  task automatic check_all();
    int oi;
    bit v, x;
    oi = (own < 0) ? 0 : own;
    v = own >= 0;
    x = expiring();
    chk("cyc_o", cyc_o, v & c[oi]);
    chk("stb_o", stb_o, v & s[oi]);
    chk("we_o", we_o, v & w[oi]);
    chk("sel_o", sel_o, v ? sl[oi] : 2'b00);
    chk("adr_o", adr_o, v ? a[oi] : '0);
    chk("dat_o", dat_o, v ? d[oi] : '0);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("m%0d_ack_o", n), ack_o[n], own == n && ack_i && s[n]);
      chk($sformatf("m%0d_err_o", n), err_o[n], own == n && x);
      chk($sformatf("m%0d_dat_o", n), dat_m[n], own == n ? dat_i : '0);
      chk($sformatf("m%0d_gnt_o", n), gnt_o[n], own == n);
    end
  endtask

  task automatic update();
    int o;
    bit x;
    bit r[2];
    o = own;
    x = expiring();
    for (int n = 0; n < 2; n++) r[n] = c[n] && !blk[n];
    if (ack_i || o < 0 || !c[o]) tcnt = 0;
    else if (s[o]) tcnt++;
    for (int n = 0; n < 2; n++) blk[n] = (blk[n] || (x && o == n)) && c[n];
    if (o < 0) begin
      if (r[0] && r[1]) own = (last == 0) ? 1 : 0;
      else if (r[0]) own = 0;
      else if (r[1]) own = 1;
    end else if (x || !c[o]) begin
      last = o;
      own = (!x && r[1-o]) ? 1 - o : -1;
    end
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic clr_in();
    for (int n = 0; n < 2; n++) begin
      c[n] = 0; s[n] = 0; w[n] = 0; sl[n] = 0; a[n] = 0; d[n] = 0;
    end
    ack_i = 0;
    dat_i = 0;
  endtask

  task automatic do_reset();
    arst = 1;
    model_reset();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    arst = 0;
  endtask

  initial begin
    int n_to;
    bit found;
    int q[$];
    bit pg[2];
    bit dn[2];
    int o0, first;
    compared = 0;
    mismatched = 0;
    clr_in();
    do_reset();

    // single read by m0, slave acks on the third bus cycle
    c[0] = 1; s[0] = 1; a[0] = 15'h0100; sl[0] = 2'b11;
    #1 chk("t1_idle_cyc", cyc_o, 0);
    step();
    #1 chk("t1_cyc_up", cyc_o, 1);
    chk("t1_adr", adr_o, 15'h0100);
    step();
    step();
    ack_i = 1; dat_i = 16'hBEEF;
    #1 chk("t1_ack0", ack_o[0], 1);
    chk("t1_dat0", dat_m[0], 16'hBEEF);
    chk("t1_ack1", ack_o[1], 0);
    step();
    clr_in();
    step();
    step();

    // simultaneous request after reset: m0 first, then one-cycle gap to m1
    do_reset();
    c[0] = 1; s[0] = 1; c[1] = 1; s[1] = 1; a[1] = 15'h7abc;
    step();
    #1 chk("t2_gnt0", gnt_o[0], 1);
    chk("t2_gnt1", gnt_o[1], 0);
    step();
    c[0] = 0; s[0] = 0;
    #1 chk("t2_gap_cyc", cyc_o, 0);
    step();
    #1 chk("t2_m1_gnt", gnt_o[1], 1);
    chk("t2_m1_cyc", cyc_o, 1);
    step();
    c[1] = 0; s[1] = 0;
    step();
    step();

    // m1 holds cyc across three transfers while m0 waits
    c[1] = 1;
    step();
    c[0] = 1; s[0] = 1;
    for (int k = 0; k < 3; k++) begin
      s[1] = 1; ack_i = 1; dat_i = W'($urandom);
      #1 chk("t3_m0_wait", gnt_o[0], 0);
      step();
      s[1] = 0; ack_i = 0;
      #1 chk("t3_m1_hold", gnt_o[1], 1);
      step();
    end
    c[1] = 0;
    #1 chk("t3_rel_gnt0", gnt_o[0], 0);
    step();
    #1 chk("t3_m0_gnt", gnt_o[0], 1);
    step();
    clr_in();
    step();
    step();

    // continuous competing requests: grants must alternate
    first = (last == 0) ? 1 : 0;
    for (int n = 0; n < 2; n++) begin pg[n] = 0; dn[n] = 0; end
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < 2; n++) begin c[n] = !(own == n && dn[n]); s[n] = c[n]; end
      o0 = own;
      #1;
      for (int n = 0; n < 2; n++) begin
        if (gnt_o[n] && !pg[n]) q.push_back(n);
        pg[n] = gnt_o[n];
      end
      step();
      for (int n = 0; n < 2; n++) dn[n] = (o0 == n) && c[n];
    end
    chk("t4_grants", q.size() >= 6, 1);
    if (q.size() > 0) chk("t4_first", q[0], first);
    for (int i = 1; i < q.size(); i++) chk("t4_alt", q[i], q[i-1] ^ 1);
    clr_in();

    // asynchronous reset in the middle of an m1 write
    do_reset();
    c[1] = 1; s[1] = 1; w[1] = 1; a[1] = 15'h1234; d[1] = 16'hCAFE; sl[1] = 2'b01;
    step();
    #1 chk("t5_we_up", we_o, 1);
    arst = 1;
    #1 chk("t5_cyc", cyc_o, 0);
    chk("t5_stb", stb_o, 0);
    chk("t5_we", we_o, 0);
    chk("t5_gnt1", gnt_o[1], 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    arst = 0;
    step();
    step();
    clr_in();
    step();
    step();

`ifdef XM_BUS_ARB_TIMEOUT_EN
    // hung slave: m0 errors on the 64th stalled strobe, m1 takes over
    do_reset();
    c[0] = 1; s[0] = 1; c[1] = 1;
    step();
    found = 0; n_to = 0;
    for (int k = 1; k <= 80 && !found; k++) begin
      #1;
      if (err_o[0]) begin found = 1; n_to = k; end
      step();
    end
    chk("to_cycle", n_to, TO);
    #1 chk("to_idle_gnt0", gnt_o[0], 0);
    step();
    #1 chk("to_m1_gnt", gnt_o[1], 1);
    step();
    c[1] = 0;
    step();
    #1 chk("to_blocked", gnt_o[0], 0);
    step();
    c[0] = 0;
    step();
    c[0] = 1;
    step();
    #1 chk("to_regrant", gnt_o[0], 1);
    clr_in();
    step();
    step();
`else
    // hung slave without watchdog: m0 keeps the bus, no error
    do_reset();
    c[0] = 1; s[0] = 1; c[1] = 1;
    for (int k = 0; k < 100; k++) step();
    #1 chk("hung_hold", gnt_o[0], 1);
    chk("hung_err", err_o[0], 0);
    clr_in();
    step();
    step();
`endif

    // random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int n = 0; n < 2; n++) begin
        c[n] = c[n] ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
        s[n] = c[n] & 1'($urandom_range(0, 1));
        w[n] = 1'($urandom);
        sl[n] = 2'($urandom);
        a[n] = AW'($urandom);
        d[n] = W'($urandom);
      end
      ack_i = 1'($urandom_range(0, 1));
      dat_i = W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
